risc16_control_unit: RTL and testbench
======================================

# risc16_control_unit

Control unit of the 16-bit RISC processor. It holds the instruction register and a clock-enable divider that paces the control FSM. It sequences fetch, decode and execute, and drives strobes and selects to the program counter, memory bank and datapath. It sits between the memory bank (instruction source) and the PC/datapath; the PC and datapath themselves are outside this block.

## Interface
Parameters:
- TICK_DIV, default 4: CLK100MHZ cycles per FSM step (≥2).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- CLK100MHZ  in  1  system clock; every register in the block uses it.
- rst_n  in  1  asynchronous, active-low reset.
- mb_data_in  in  16  memory read data; the IR captures it.
- dp_zf_flag  in  1  datapath zero flag.
- slow_tick  out  1  one-cycle enable, high once every TICK_DIV cycles.
- ir_inst  out  16  instruction register contents.
- pc_clear, pc_inc, pc_load  out  1 each  PC strobes. pc_load tells the PC to add the signed ir_inst[7:0] to its current (already incremented) value.
- ir_load  out  1  IR capture strobe; also exported.
- mb_sel  out  1  memory address source: 0 = PC, 1 = mb_addr.
- mb_addr  out  8  data address.
- mb_read, mb_write  out  1 each  memory read level and write strobe.
- dp_imm  out  8  immediate.
- dp_sel  out  2  register-file write source: 0 = ALU, 1 = memory, 2 = immediate.
- dp_write_addr  out  4  write address; dp_write  out  1  write strobe.
- dp_a_addr, dp_b_addr  out  4 each  read addresses.
- dp_a_read, dp_b_read  out  1 each  read enables.
- dp_alu_sel  out  4  ALU operation.
- state  out  4  current FSM state (diagnostic).

## Operation
- ISA fields: opcode ir[15:12], rd/ra ir[11:8], rs ir[7:4], rt ir[3:0], k ir[7:0].
- 0x0 LOAD: R[rd] ← M[k].
- 0x1 STORE: M[k] ← R[rd].
- 0x2 LOADI: R[rd] ← k.
- 0x3 JMPZ: if R[ra] = 0, PC += signed k.
- 0x4–0xF ALU: R[rd] ← R[rs] op R[rt], with op = opcode.
- Always driven: mb_addr = dp_imm = ir[7:0].
- States and encodings: INIT=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, LOADI=5, ALU=6, JMPZ=7, JMP=8.
- State transitions:
  - INIT → FETCH.
  - FETCH → DECODE.
  - DECODE → by opcode.
  - LOAD, STORE, LOADI, ALU and JMP → FETCH.
  - JMPZ → JMP if dp_zf_flag = 1, else FETCH.
  - Unused encodings → INIT.
- Per-state outputs. Every output not listed here is 0.
  - INIT: pc_clear.
  - FETCH: mb_sel=0, mb_read=1, ir_load, pc_inc.
  - LOAD: mb_sel=1, mb_read=1, dp_sel=1, dp_write_addr=rd, dp_write.
  - STORE: mb_sel=1, dp_a_addr=rd, dp_a_read=1, mb_write.
  - LOADI: dp_sel=2, dp_write_addr=rd, dp_write.
  - ALU: dp_sel=0, dp_write_addr=rd, dp_a_addr=rs, dp_b_addr=rt, dp_a_read=dp_b_read=1, dp_alu_sel=opcode, dp_write.
  - JMPZ: dp_a_addr=ra, dp_a_read=1, dp_alu_sel=0 (pass A).
  - JMP: pc_load.
- IR: on ir_load, ir_inst ← mb_data_in; otherwise it holds its value.

## Timing
- Reset: the divider counter, state (INIT) and ir_inst (0x0000) all clear. With all strobes at 0, every output is 0.
- slow_tick: a counter runs 0..TICK_DIV-1. slow_tick is high in the cycle where count = TICK_DIV-1. The first tick after reset release comes TICK_DIV cycles later.
- The FSM changes state only on clock edges where slow_tick = 1. Each state therefore dwells exactly TICK_DIV cycles.
- Level outputs (selects, addresses, read enables, alu_sel) are combinational from state and ir_inst. They are stable for the whole dwell.
- Strobes (pc_clear, pc_inc, pc_load, ir_load, mb_write, dp_write) are the state decode ANDed with slow_tick. Each is a single CLK100MHZ cycle wide, in the last cycle of its state.
- In FETCH, ir_load and pc_inc fire on the same edge. The IR captures data read at the old PC.
- dp_zf_flag is sampled only on the JMPZ tick edge.
- Instruction latency: 3 ticks (FETCH, DECODE, execute). Taken JMPZ takes 4.
- Reset asserted mid-instruction forces INIT immediately. Partial strobes are dropped and the divider restarts.

## Test plan
- Reset and tick spacing: hold rst_n=0, then release. Required: state=0, ir_inst=0, all outputs 0 during reset. First slow_tick after 4 cycles, then every 4. One pc_clear pulse, then state=1.
- ALU fetch: mb_data_in=0x83A0. Required: ir_load and pc_inc one-cycle pulses at the end of FETCH; ir_inst=0x83A0; state 1→2→6. In ALU: dp_write_addr=3, dp_a_addr=0xA, dp_b_addr=0, dp_alu_sel=8, dp_sel=0, a single dp_write pulse; then FETCH.
- Store: mb_data_in=0x1321. Required: state 4, mb_sel=1, mb_addr=0x21, dp_a_addr=3, dp_a_read=1, one mb_write pulse, dp_write never asserted.
- Load and immediate:
  - 0x0512: state 3, mb_read=1, dp_sel=1, write to R5.
  - 0x27FF: state 5, dp_imm=0xFF, dp_sel=2, write to R7.
- Jump: 0x34F0 with dp_zf_flag=1 → JMPZ (dp_a_addr=4, dp_alu_sel=0), then JMP, one pc_load pulse, then FETCH. With dp_zf_flag=0 → FETCH directly, no pc_load.
- Reset mid-operation: drop rst_n during the ALU state before its tick. Required: no dp_write pulse, immediate state=0, ir_inst=0.

Source files
------------

// File: rtl/risc16_control_unit.sv
// risc16_control_unit: instruction register, clock-enable divider and the
// fetch/decode/execute sequencer driving the PC, memory bank and datapath.
module risc16_control_unit #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic [15:0] mb_data_in,
    input  logic        dp_zf_flag,
    output logic        slow_tick,
    output logic [15:0] ir_inst,
    output logic        pc_clear,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        ir_load,
    output logic        mb_sel,
    output logic [7:0]  mb_addr,
    output logic        mb_read,
    output logic        mb_write,
    output logic [7:0]  dp_imm,
    output logic [1:0]  dp_sel,
    output logic [3:0]  dp_write_addr,
    output logic        dp_write,
    output logic [3:0]  dp_a_addr,
    output logic [3:0]  dp_b_addr,
    output logic        dp_a_read,
    output logic        dp_b_read,
    output logic [3:0]  dp_alu_sel,
    output logic [3:0]  state
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_LOADI  = 4'd5,
        S_ALU    = 4'd6,
        S_JMPZ   = 4'd7,
        S_JMP    = 4'd8
    } state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;

    // Divider count: wraps at TICK_DIV-1, the tick cycle.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

    assign slow_tick = (cnt_q == CNT_MAX);

    // Next state: advances only on the tick cycle.
    always_comb begin
        state_d = state_q;
        if (slow_tick) begin
            case (state_q)
                S_INIT:   state_d = S_FETCH;
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (ir_q[15:12])
                        4'h0:    state_d = S_LOAD;
                        4'h1:    state_d = S_STORE;
                        4'h2:    state_d = S_LOADI;
                        4'h3:    state_d = S_JMPZ;
                        default: state_d = S_ALU;
                    endcase
                end
                S_LOAD, S_STORE, S_LOADI, S_ALU, S_JMP: state_d = S_FETCH;
                S_JMPZ:   state_d = dp_zf_flag ? S_JMP : S_FETCH;
                default:  state_d = S_INIT;
            endcase
        end
    end

    // IR captures memory data on the fetch strobe, otherwise holds.
    always_comb begin
        ir_d = ir_load ? mb_data_in : ir_q;
    end

    // Divider, state and IR registers.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= S_INIT;
            ir_q    <= 16'h0000;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign ir_inst = ir_q;
    assign state   = state_q;
    assign mb_addr = ir_q[7:0];
    assign dp_imm  = ir_q[7:0];

    // Per-state selects/addresses; strobes gated to the last cycle of the dwell.
    always_comb begin
        pc_clear      = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        ir_load       = 1'b0;
        mb_sel        = 1'b0;
        mb_read       = 1'b0;
        mb_write      = 1'b0;
        dp_sel        = 2'd0;
        dp_write_addr = 4'd0;
        dp_write      = 1'b0;
        dp_a_addr     = 4'd0;
        dp_b_addr     = 4'd0;
        dp_a_read     = 1'b0;
        dp_b_read     = 1'b0;
        dp_alu_sel    = 4'd0;
        case (state_q)
            S_INIT: pc_clear = slow_tick;
            S_FETCH: begin
                mb_read = 1'b1;
                ir_load = slow_tick;
                pc_inc  = slow_tick;
            end
            S_LOAD: begin
                mb_sel        = 1'b1;
                mb_read       = 1'b1;
                dp_sel        = 2'd1;
                dp_write_addr = ir_q[11:8];
                dp_write      = slow_tick;
            end
            S_STORE: begin
                mb_sel    = 1'b1;
                dp_a_addr = ir_q[11:8];
                dp_a_read = 1'b1;
                mb_write  = slow_tick;
            end
            S_LOADI: begin
                dp_sel        = 2'd2;
                dp_write_addr = ir_q[11:8];
                dp_write      = slow_tick;
            end
            S_ALU: begin
                dp_sel        = 2'd0;
                dp_write_addr = ir_q[11:8];
                dp_a_addr     = ir_q[7:4];
                dp_b_addr     = ir_q[3:0];
                dp_a_read     = 1'b1;
                dp_b_read     = 1'b1;
                dp_alu_sel    = ir_q[15:12];
                dp_write      = slow_tick;
            end
            S_JMPZ: begin
                dp_a_addr  = ir_q[11:8];
                dp_a_read  = 1'b1;
                dp_alu_sel = 4'd0;
            end
            S_JMP: pc_load = slow_tick;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc16_control_unit.sv
// Bench for risc16_control_unit: directed and random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_risc16_control_unit;

    localparam int unsigned TD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] mb_data_in;
    logic        dp_zf_flag;
    logic        slow_tick, pc_clear, pc_inc, pc_load, ir_load;
    logic [15:0] ir_inst;
    logic        mb_sel, mb_read, mb_write;
    logic [7:0]  mb_addr, dp_imm;
    logic [1:0]  dp_sel;
    logic [3:0]  dp_write_addr, dp_a_addr, dp_b_addr, dp_alu_sel, state;
    logic        dp_write, dp_a_read, dp_b_read;

    int checks   = 0;
    int failures = 0;
    logic [15:0] ir_model = 16'h0000;

    risc16_control_unit #(.TICK_DIV(TD)) dut (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .mb_data_in   (mb_data_in),
        .dp_zf_flag   (dp_zf_flag),
        .slow_tick    (slow_tick),
        .ir_inst      (ir_inst),
        .pc_clear     (pc_clear),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .ir_load      (ir_load),
        .mb_sel       (mb_sel),
        .mb_addr      (mb_addr),
        .mb_read      (mb_read),
        .mb_write     (mb_write),
        .dp_imm       (dp_imm),
        .dp_sel       (dp_sel),
        .dp_write_addr(dp_write_addr),
        .dp_write     (dp_write),
        .dp_a_addr    (dp_a_addr),
        .dp_b_addr    (dp_b_addr),
        .dp_a_read    (dp_a_read),
        .dp_b_read    (dp_b_read),
        .dp_alu_sel   (dp_alu_sel),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every output packed into one word for whole-interface comparison.
    logic [64:0] obs;
    assign obs = {state, slow_tick, pc_clear, pc_inc, pc_load, ir_load, mb_sel, mb_addr,
                  mb_read, mb_write, dp_imm, dp_sel, dp_write_addr, dp_write, dp_a_addr,
                  dp_b_addr, dp_a_read, dp_b_read, dp_alu_sel, ir_inst};

    // Expected outputs for one cycle of a given phase, IR contents and tick position.
    function automatic logic [64:0] model(input int unsigned ph, input logic [15:0] ir, input bit tk);
        logic [3:0] st = 4'(ph);
        logic clr = 0, inc = 0, ld = 0, irl = 0, msel = 0, mrd = 0, mwr = 0;
        logic [1:0] sel = 0;
        logic [3:0] wa = 0, aa = 0, ba = 0, alu = 0;
        logic wr = 0, ar = 0, br = 0;
        case (ph)
            0: clr = tk;
            1: begin mrd = 1; irl = tk; inc = tk; end
            3: begin msel = 1; mrd = 1; sel = 2'd1; wa = ir[11:8]; wr = tk; end
            4: begin msel = 1; aa = ir[11:8]; ar = 1; mwr = tk; end
            5: begin sel = 2'd2; wa = ir[11:8]; wr = tk; end
            6: begin wa = ir[11:8]; aa = ir[7:4]; ba = ir[3:0]; ar = 1; br = 1;
                     alu = ir[15:12]; wr = tk; end
            7: begin aa = ir[11:8]; ar = 1; end
            8: ld = tk;
            default: ;
        endcase
        return {st, tk, clr, inc, ld, irl, msel, ir[7:0], mrd, mwr, ir[7:0], sel, wa, wr,
                aa, ba, ar, br, alu, ir};
    endfunction

    // Holds reset a few cycles, releases it, then walks the INIT phase.
    task automatic release_and_init(input string nm);
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 65'd0) begin
                failures++;
                $display("FAIL %s in_reset obs=%h exp=0", nm, obs);
            end
        end
        rst_n = 1'b1;
        ir_model = 16'h0000;
        for (int c = 0; c < TD; c++) begin
            checks++;
            if (obs !== model(0, 16'h0000, c == TD - 1)) begin
                failures++;
                $display("FAIL %s init cyc=%0d obs=%h exp=%h", nm, c, obs,
                         model(0, 16'h0000, c == TD - 1));
            end
            @(posedge clk); #1;
        end
    endtask

    // Runs one instruction from the start of FETCH, comparing every cycle.
    // With abort set, reset is asserted one cycle into the execute phase.
    task automatic exec_instr(input string nm, input logic [15:0] inst, input bit zf,
                              input bit abort);
        int unsigned exec_of[4] = '{3, 4, 5, 7};
        int unsigned ph[$];
        int unsigned ex;
        logic [15:0] ir_now;
        logic [64:0] e;
        mb_data_in = inst;
        dp_zf_flag = zf;
        ex = (inst[15:12] >= 4'd4) ? 6 : exec_of[inst[13:12]];
        ph = '{1, 2};
        ph.push_back(ex);
        if (ex == 7 && zf) ph.push_back(8);
        ir_now = ir_model;
        foreach (ph[i]) begin
            for (int c = 0; c < TD; c++) begin
                if (abort && i == 2 && c == 1) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if (obs !== 65'd0) begin
                        failures++;
                        $display("FAIL %s reset_mid obs=%h exp=0", nm, obs);
                    end
                    ir_model = 16'h0000;
                    return;
                end
                e = model(ph[i], ir_now, c == TD - 1);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s inst=%h ph=%0d cyc=%0d obs=%h exp=%h", nm, inst, ph[i],
                             c, obs, e);
                end
                @(posedge clk); #1;
                if (ph[i] == 1 && c == TD - 1) ir_now = inst;
            end
        end
        ir_model = ir_now;
    endtask

    task automatic test_reset;
        release_and_init("reset");
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL reset_to_fetch state=%0d exp=1", state);
        end
    endtask

    task automatic test_alu;
        exec_instr("alu", 16'h83A0, 1'b0, 1'b0);
        checks++;
        if (ir_inst !== 16'h83A0) begin
            failures++;
            $display("FAIL alu_ir ir_inst=%h exp=83a0", ir_inst);
        end
    endtask

    task automatic test_store;
        exec_instr("store", 16'h1321, 1'b0, 1'b0);
    endtask

    task automatic test_load_imm;
        exec_instr("load", 16'h0512, 1'b0, 1'b0);
        exec_instr("loadi", 16'h27FF, 1'b0, 1'b0);
    endtask

    task automatic test_jump;
        exec_instr("jmpz_taken", 16'h34F0, 1'b1, 1'b0);
        exec_instr("jmpz_not", 16'h34F0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 40; n++)
            exec_instr("random", 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
    endtask

    task automatic test_reset_mid;
        exec_instr("mid", 16'h4123, 1'b0, 1'b1);
        release_and_init("mid");
        exec_instr("after_mid", 16'h2A5C, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        mb_data_in = 16'h0000;
        dp_zf_flag = 1'b0;
        test_reset();
        test_alu();
        test_store();
        test_load_imm();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
